// File: rtl/bram_arbiter_if.sv
// ============================================================================
// Module : bram_arbiter_if
// Brief  : Requester port bundle for bram_arbiter (one instance per requester).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface bram_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADD_WIDTH  = 4,
    parameter int PIPE_SIZE  = 4
);
    logic                            req;
    logic                            we;
    logic [ADD_WIDTH-1:0]            add;
    logic [DATA_WIDTH-1:0]           wdata;
    logic                            gnt;
    logic                            rvalid;
    logic [DATA_WIDTH*PIPE_SIZE-1:0] rdata;

    modport master (
        output req, we, add, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, add, wdata,
        output gnt, rvalid, rdata
    );
endinterface

`default_nettype wire

// File: rtl/bram_arbiter.sv
// ============================================================================
// Module : bram_arbiter
// Brief  : Round-robin two-port arbiter in front of a wide-read block RAM.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bram_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADD_WIDTH  = 4,
    parameter int PIPE_SIZE  = 4
) (
    input  wire logic                            clk,
    input  wire logic                            rst_n,
    bram_arbiter_if.slave                        r0,
    bram_arbiter_if.slave                        r1,
    output logic                                 ram_cs,
    output logic                                 ram_we,
    output logic                                 ram_oe,
    output logic [ADD_WIDTH-1:0]                 ram_add,
    output logic [DATA_WIDTH-1:0]                ram_din,
    input  wire logic [DATA_WIDTH*PIPE_SIZE-1:0] ram_dout
);

    // Reads fetch a whole PIPE_SIZE-aligned block, so the low address bits are cleared.
    localparam logic [ADD_WIDTH-1:0] c_ALIGN_MASK = ~(ADD_WIDTH'(PIPE_SIZE - 1));

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCESS  = 2'd1,
        S_CAPTURE = 2'd2
    } state_t;

    state_t                          r_state;
    state_t                          w_state_next;

    logic                            r_ptr;
    logic                            r_sel;
    logic                            r_we;
    logic [1:0]                      r_gnt;
    logic [1:0]                      r_rvalid;
    logic [DATA_WIDTH*PIPE_SIZE-1:0] r_rdata0;
    logic [DATA_WIDTH*PIPE_SIZE-1:0] r_rdata1;
    logic                            r_ram_cs;
    logic                            r_ram_we;
    logic                            r_ram_oe;
    logic [ADD_WIDTH-1:0]            r_ram_add;
    logic [DATA_WIDTH-1:0]           r_ram_din;

    logic [1:0]                      w_req;
    logic                            w_accept;
    logic                            w_pick;
    logic                            w_pick_we;
    logic [ADD_WIDTH-1:0]            w_pick_add;
    logic [DATA_WIDTH-1:0]           w_pick_wdata;

    always_comb begin
        w_req        = {r1.req, r0.req};
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_pick       = r_ptr;
        case (r_state)
            S_IDLE: begin
                if (|w_req) begin
                    w_accept     = 1'b1;
                    w_state_next = S_ACCESS;
                    w_pick       = (w_req == 2'b11) ? r_ptr : w_req[1];
                end
            end
            S_ACCESS: w_state_next = r_we ? S_IDLE : S_CAPTURE;
            default:  w_state_next = S_IDLE;
        endcase
        w_pick_we    = w_pick ? r1.we    : r0.we;
        w_pick_add   = w_pick ? r1.add   : r0.add;
        w_pick_wdata = w_pick ? r1.wdata : r0.wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Every output is registered: the ACCESS-cycle strobes are loaded on the accepting edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr     <= 1'b0;
            r_sel     <= 1'b0;
            r_we      <= 1'b0;
            r_gnt     <= 2'b00;
            r_rvalid  <= 2'b00;
            r_rdata0  <= '0;
            r_rdata1  <= '0;
            r_ram_cs  <= 1'b0;
            r_ram_we  <= 1'b0;
            r_ram_oe  <= 1'b0;
            r_ram_add <= '0;
            r_ram_din <= '0;
        end else begin
            r_gnt    <= w_accept ? (w_pick ? 2'b10 : 2'b01) : 2'b00;
            r_ram_cs <= w_accept;
            r_ram_we <= w_accept & w_pick_we;
            r_ram_oe <= w_accept & ~w_pick_we;
            r_rvalid <= 2'b00;
            if (w_accept) begin
                r_sel     <= w_pick;
                r_ptr     <= ~w_pick;
                r_we      <= w_pick_we;
                r_ram_add <= w_pick_we ? w_pick_add : (w_pick_add & c_ALIGN_MASK);
                r_ram_din <= w_pick_wdata;
            end
            if (r_state == S_CAPTURE) begin
                r_rvalid <= r_sel ? 2'b10 : 2'b01;
                if (r_sel) begin
                    r_rdata1 <= ram_dout;
                end else begin
                    r_rdata0 <= ram_dout;
                end
            end
        end
    end

    assign r0.gnt    = r_gnt[0];
    assign r1.gnt    = r_gnt[1];
    assign r0.rvalid = r_rvalid[0];
    assign r1.rvalid = r_rvalid[1];
    assign r0.rdata  = r_rdata0;
    assign r1.rdata  = r_rdata1;
    assign ram_cs    = r_ram_cs;
    assign ram_we    = r_ram_we;
    assign ram_oe    = r_ram_oe;
    assign ram_add   = r_ram_add;
    assign ram_din   = r_ram_din;

endmodule

`default_nettype wire

// File: tb/tb_bram_arbiter.sv
// ============================================================================
// Module : tb_bram_arbiter
// Brief  : Directed self-checking bench for bram_arbiter with a behavioural RAM.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bram_arbiter;
    localparam int DW = 32;
    localparam int AW = 4;
    localparam int PS = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bram_arbiter_if #(.DATA_WIDTH(DW), .ADD_WIDTH(AW), .PIPE_SIZE(PS)) r0_if ();
    bram_arbiter_if #(.DATA_WIDTH(DW), .ADD_WIDTH(AW), .PIPE_SIZE(PS)) r1_if ();

    logic              ram_cs, ram_we, ram_oe;
    logic [AW-1:0]     ram_add;
    logic [DW-1:0]     ram_din;
    logic [DW*PS-1:0]  ram_dout;
    logic [DW-1:0]     mem [16];

    int checks = 0;
    int errors = 0;
    logic [DW*PS-1:0] sb [$];
    int               gseq [$];

    localparam logic [DW*PS-1:0] c_BLK4 = {32'd12, 32'd0, 32'd12323, 32'd12341234};

    bram_arbiter #(.DATA_WIDTH(DW), .ADD_WIDTH(AW), .PIPE_SIZE(PS)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .r0       (r0_if),
        .r1       (r1_if),
        .ram_cs   (ram_cs),
        .ram_we   (ram_we),
        .ram_oe   (ram_oe),
        .ram_add  (ram_add),
        .ram_din  (ram_din),
        .ram_dout (ram_dout)
    );

    // Behavioural RAM: preloaded while reset is low, read data one cycle after cs&oe.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
            mem[4]   <= 32'd12341234;
            mem[5]   <= 32'd12323;
            mem[6]   <= 32'd0;
            mem[7]   <= 32'd12;
            ram_dout <= '0;
        end else begin
            if (ram_cs && ram_we) mem[ram_add] <= ram_din;
            if (ram_cs && ram_oe)
                ram_dout <= {mem[AW'(ram_add + 3)], mem[AW'(ram_add + 2)],
                             mem[AW'(ram_add + 1)], mem[ram_add]};
        end
    end

    task automatic check(input string tag, input logic [DW*PS-1:0] obs, input logic [DW*PS-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int port, input logic req, input logic we,
                         input logic [AW-1:0] add, input logic [DW-1:0] wdata);
        if (port == 0) begin
            r0_if.req = req; r0_if.we = we; r0_if.add = add; r0_if.wdata = wdata;
        end else begin
            r1_if.req = req; r1_if.we = we; r1_if.add = add; r1_if.wdata = wdata;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [DW*PS-1:0] exp_rd;
        int both_cnt;
        int rv_cnt;

        // Reset with a request pending: nothing may happen.
        drive(0, 1'b1, 1'b1, 4'd3, 32'd23);
        drive(1, 1'b0, 1'b0, 4'd0, 32'd0);
        tick(); tick();
        check("rst_gnt",    {r1_if.gnt, r0_if.gnt}, 2'b00);
        check("rst_strobe", {ram_cs, ram_we, ram_oe}, 3'b000);
        check("rst_add",    ram_add, 4'd0);
        check("rst_din",    ram_din, 32'd0);
        check("rst_rdata",  r0_if.rdata | r1_if.rdata, '0);

        // Port0 write add=3 wdata=23, granted on first edge after release.
        rst_n = 1'b1;
        tick();
        check("wr_gnt",    {r1_if.gnt, r0_if.gnt}, 2'b01);
        check("wr_strobe", {ram_cs, ram_we, ram_oe}, 3'b110);
        check("wr_add",    ram_add, 4'd3);
        check("wr_din",    ram_din, 32'd23);
        drive(0, 1'b0, 1'b0, 4'd0, 32'd0);
        tick();
        check("wr_gnt_off",    {r1_if.gnt, r0_if.gnt}, 2'b00);
        check("wr_strobe_off", {ram_cs, ram_we, ram_oe}, 3'b000);
        check("wr_add_hold",   ram_add, 4'd3);
        check("wr_mem",        mem[3], 32'd23);

        // Port1 read add=4.
        drive(1, 1'b1, 1'b0, 4'd4, 32'd0);
        tick();
        check("rd1_gnt",    {r1_if.gnt, r0_if.gnt}, 2'b10);
        check("rd1_strobe", {ram_cs, ram_we, ram_oe}, 3'b101);
        check("rd1_add",    ram_add, 4'd4);
        sb.push_back(c_BLK4);
        drive(1, 1'b0, 1'b0, 4'd0, 32'd0);
        tick();
        check("rd1_rv_early", {r1_if.rvalid, r0_if.rvalid}, 2'b00);
        tick();
        check("rd1_rv", {r1_if.rvalid, r0_if.rvalid}, 2'b10);
        exp_rd = (sb.size() != 0) ? sb.pop_front() : '1;
        check("rd1_data",   r1_if.rdata, exp_rd);
        check("rd1_r0hold", r0_if.rdata, '0);
        tick();
        check("rd1_rv_pulse", {r1_if.rvalid, r0_if.rvalid}, 2'b00);

        // Port0 read add=5 is aligned down to 4; port1 data must hold.
        drive(0, 1'b1, 1'b0, 4'd5, 32'd0);
        tick();
        check("rd0_gnt", {r1_if.gnt, r0_if.gnt}, 2'b01);
        check("rd0_add", ram_add, 4'd4);
        sb.push_back(c_BLK4);
        drive(0, 1'b0, 1'b0, 4'd0, 32'd0);
        tick(); tick();
        check("rd0_rv", {r1_if.rvalid, r0_if.rvalid}, 2'b01);
        exp_rd = (sb.size() != 0) ? sb.pop_front() : '1;
        check("rd0_data",   r0_if.rdata, exp_rd);
        check("rd0_r1hold", r1_if.rdata, c_BLK4);

        // Both ports request continuously after reset: grants alternate 0,1,0,1.
        rst_n = 1'b0;
        tick(); tick();
        drive(0, 1'b1, 1'b1, 4'd8, 32'hAAAA);
        drive(1, 1'b1, 1'b1, 4'd9, 32'hBBBB);
        rst_n = 1'b1;
        both_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (r0_if.gnt && r1_if.gnt) both_cnt++;
            if (r0_if.gnt) gseq.push_back(0);
            if (r1_if.gnt) gseq.push_back(1);
        end
        drive(0, 1'b0, 1'b0, 4'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 4'd0, 32'd0);
        check("rr_both",  both_cnt, 0);
        check("rr_count", gseq.size(), 5);
        for (int i = 0; i < 4; i++) begin
            exp_rd = (i % 2);
            check($sformatf("rr_seq%0d", i), (gseq.size() > i) ? gseq[i] : 9, exp_rd);
        end
        check("rr_mem8", mem[8], 32'hAAAA);
        check("rr_mem9", mem[9], 32'hBBBB);
        tick(); tick();

        // Port1 read (refreshes r1 data), then reset during CAPTURE.
        drive(1, 1'b1, 1'b0, 4'd4, 32'd0);
        tick();
        check("ab_gnt", {r1_if.gnt, r0_if.gnt}, 2'b10);
        drive(1, 1'b0, 1'b0, 4'd0, 32'd0);
        tick();
        rst_n = 1'b0;
        #1;
        check("ab_rdata",  r1_if.rdata, '0);
        check("ab_rvalid", {r1_if.rvalid, r0_if.rvalid}, 2'b00);
        check("ab_strobe", {ram_cs, ram_we, ram_oe}, 3'b000);
        tick(); tick();
        rst_n = 1'b1;
        rv_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            if (r0_if.rvalid || r1_if.rvalid || r0_if.gnt || r1_if.gnt) rv_cnt++;
            tick();
        end
        check("ab_no_rv", rv_cnt, 0);
        check("ab_rdata_after", r1_if.rdata, '0);

        // Pointer back at port 0 and FSM idle: immediate grant to port 0.
        drive(0, 1'b1, 1'b1, 4'd10, 32'd77);
        drive(1, 1'b1, 1'b1, 4'd11, 32'd88);
        tick();
        check("ab_ptr", {r1_if.gnt, r0_if.gnt}, 2'b01);
        drive(0, 1'b0, 1'b0, 4'd0, 32'd0);
        tick(); tick();
        check("ab_next", {r1_if.gnt, r0_if.gnt}, 2'b10);
        drive(1, 1'b0, 1'b0, 4'd0, 32'd0);
        tick(); tick();
        check("sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
